// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter/sequencer.
package alu_arb_pkg;

    localparam int W = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's view of the arbiter: request handshake plus held response handshake.
interface alu_req_if;
    import alu_arb_pkg::*;

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [2:0]   req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_res;
    logic         rsp_zero;
    logic         rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_zero, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_zero, rsp_ovf
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker: a tie goes to the port that did not win last time.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Pick the granted port from the current request set
    always_comb begin
        grant_valid = |valid;
        case (valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: round-robin grant,
// registered operands, one execute cycle, then a held response to the owner.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    alu_req_if.slave     port0,
    alu_req_if.slave     port1,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_res,
    input  logic         alu_zero,
    input  logic         alu_ovf
);

    state_t       state_r;
    logic         last_grant_r;
    logic         owner_r;
    logic [W-1:0] alu_a_r;
    logic [W-1:0] alu_b_r;
    logic [2:0]   alu_op_r;
    logic [1:0]   rsp_valid_r;
    logic [W-1:0] rsp_res_r [2];
    logic [1:0]   rsp_zero_r;
    logic [1:0]   rsp_ovf_r;

    logic [1:0]   req_valid_s;
    logic [1:0]   req_ready_s;
    logic         grant_valid_s;
    logic         grant_idx_s;
    logic         rsp_ready_s;

    assign req_valid_s = {port1.req_valid, port0.req_valid};

    rr_arb2 u_rr_arb2 (
        .valid       (req_valid_s),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Ready is offered only in IDLE and only to the granted port; never during reset
    always_comb begin
        req_ready_s = 2'b00;
        if (rst_n && (state_r == IDLE) && grant_valid_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Response acceptance comes from whichever port owns the in-flight operation
    always_comb begin
        rsp_ready_s = owner_r ? port1.rsp_ready : port0.rsp_ready;
    end

    // Sequencer FSM with operand and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            alu_a_r      <= {W{1'b0}};
            alu_b_r      <= {W{1'b0}};
            alu_op_r     <= 3'b000;
            rsp_valid_r  <= 2'b00;
            rsp_res_r[0] <= {W{1'b0}};
            rsp_res_r[1] <= {W{1'b0}};
            rsp_zero_r   <= 2'b00;
            rsp_ovf_r    <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    // A grant in IDLE is always a handshake since ready follows the grant
                    if (grant_valid_s) begin
                        alu_a_r      <= grant_idx_s ? port1.req_a  : port0.req_a;
                        alu_b_r      <= grant_idx_s ? port1.req_b  : port0.req_b;
                        alu_op_r     <= grant_idx_s ? port1.req_op : port0.req_op;
                        owner_r      <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        state_r      <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_res_r[owner_r]   <= alu_res;
                    rsp_zero_r[owner_r]  <= alu_zero;
                    rsp_ovf_r[owner_r]   <= alu_ovf;
                    rsp_valid_r[owner_r] <= 1'b1;
                    state_r              <= RESP;
                end
                RESP: begin
                    if (rsp_ready_s) begin
                        rsp_valid_r <= 2'b00;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 2'b00;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign port0.req_ready = req_ready_s[0];
    assign port1.req_ready = req_ready_s[1];
    assign port0.rsp_valid = rsp_valid_r[0];
    assign port1.rsp_valid = rsp_valid_r[1];
    assign port0.rsp_res   = rsp_res_r[0];
    assign port1.rsp_res   = rsp_res_r[1];
    assign port0.rsp_zero  = rsp_zero_r[0];
    assign port1.rsp_zero  = rsp_zero_r[1];
    assign port0.rsp_ovf   = rsp_ovf_r[0];
    assign port1.rsp_ovf   = rsp_ovf_r[1];
    assign alu_a           = alu_a_r;
    assign alu_b           = alu_b_r;
    assign alu_op          = alu_op_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized operations
// checked against an opcode-level reference ALU and a grant-order model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_res;
    logic         alu_zero;
    logic         alu_ovf;
    int           checks = 0;
    int           errors = 0;

    alu_req_if port0 ();
    alu_req_if port1 ();

    alu_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .port0    (port0),
        .port1    (port1),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_res  (alu_res),
        .alu_zero (alu_zero),
        .alu_ovf  (alu_ovf)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {ovf, zero, res}
    function automatic logic [W+1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
        logic [W-1:0] r;
        logic         v;
        v = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SRL:  r = a >> b[10:6];
            OP_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            OP_SLT:  r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {v, (r == 32'd0), r};
    endfunction

    // The external ALU the block drives
    assign {alu_ovf, alu_zero, alu_res} = ref_alu(alu_a, alu_b, alu_op);

    function automatic logic rdy(input int p);
        return (p == 0) ? port0.req_ready : port1.req_ready;
    endfunction

    function automatic logic rvalid(input int p);
        return (p == 0) ? port0.rsp_valid : port1.rsp_valid;
    endfunction

    function automatic logic [W+1:0] rdata(input int p);
        return (p == 0) ? {port0.rsp_ovf, port0.rsp_zero, port0.rsp_res}
                        : {port1.rsp_ovf, port1.rsp_zero, port1.rsp_res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int p, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] op);
        if (p == 0) begin
            port0.req_valid = v; port0.req_a = a; port0.req_b = b; port0.req_op = op;
        end else begin
            port1.req_valid = v; port1.req_a = a; port1.req_b = b; port1.req_op = op;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) port0.rsp_ready = v;
        else        port1.rsp_ready = v;
    endtask

    task automatic reset_pulse();
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Issue one operation on port p with rsp_ready held high and collect the response
    task automatic run_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, output logic [W+1:0] got, output int edges,
                          output bit other_seen, output bit timed_out);
        int n;
        n = 0; edges = 0; other_seen = 1'b0; timed_out = 1'b0; got = '0;
        set_rsp_ready(0, 1'b1);
        set_rsp_ready(1, 1'b1);
        set_req(p, 1'b1, a, b, op);
        #1;
        while (!rdy(p) && n < 20) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (n >= 20) begin
            timed_out = 1'b1;
            set_req(p, 1'b0, a, b, op);
            return;
        end
        tick();
        set_req(p, 1'b0, a, b, op);
        while (!rvalid(p) && edges < 20) begin
            if (rvalid(1 - p)) other_seen = 1'b1;
            tick();
            edges++;
        end
        if (!rvalid(p)) begin
            timed_out = 1'b1;
            return;
        end
        if (rvalid(1 - p)) other_seen = 1'b1;
        got = rdata(p);
        tick();
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 32'd1, 32'd2, OP_ADD);
        set_req(1, 1'b1, 32'd3, 32'd4, OP_SUB);
        set_rsp_ready(0, 1'b1);
        set_rsp_ready(1, 1'b1);
        tick();
        #1;
        checks++;
        if ({port0.req_ready, port1.req_ready, port0.rsp_valid, port1.rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake got=%b exp=0000",
                     {port0.req_ready, port1.req_ready, port0.rsp_valid, port1.rsp_valid});
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== {W'(0), W'(0), 3'b000}) begin
            errors++;
            $display("FAIL reset_alu got a=%h b=%h op=%b exp all zero", alu_a, alu_b, alu_op);
        end
        checks++;
        if ({rdata(0), rdata(1)} !== {(2 * W + 4){1'b0}}) begin
            errors++;
            $display("FAIL reset_rsp_data got p0=%h p1=%h exp 0", rdata(0), rdata(1));
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        set_rsp_ready(0, 1'b1);
        set_req(0, 1'b1, 32'd5, 32'd7, OP_ADD);
        #1;
        checks++;
        if ({port0.req_ready, port1.req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL add_ready got=%b exp=10", {port0.req_ready, port1.req_ready});
        end
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        checks++;
        if ({port0.rsp_valid, alu_a, alu_b, alu_op} !== {1'b0, 32'd5, 32'd7, OP_ADD}) begin
            errors++;
            $display("FAIL add_exec got v=%b a=%h b=%h op=%b exp v=0 a=5 b=7 op=010",
                     port0.rsp_valid, alu_a, alu_b, alu_op);
        end
        tick();
        checks++;
        if ({port0.rsp_valid, port1.rsp_valid, rdata(0)} !== {2'b10, 1'b0, 1'b0, 32'd12}) begin
            errors++;
            $display("FAIL add_resp got v=%b%b data=%h exp v=10 data=00000000c",
                     port0.rsp_valid, port1.rsp_valid, rdata(0));
        end
        tick();
        checks++;
        if ({port0.rsp_valid, port0.rsp_res} !== {1'b0, 32'd12}) begin
            errors++;
            $display("FAIL add_after got v=%b res=%h exp v=0 res=c", port0.rsp_valid, port0.rsp_res);
        end
    endtask

    task automatic test_sub_zero();
        logic [W+1:0] got;
        int           edges;
        bit           other;
        bit           to;
        run_op(1, 32'd3, 32'd3, OP_SUB, got, edges, other, to);
        checks++;
        if (to || other || edges != 1 || got !== {1'b0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL sub_zero got=%h edges=%0d other=%b to=%b exp=%h edges=1",
                     got, edges, other, to, {1'b0, 1'b1, 32'd0});
        end
    endtask

    task automatic test_ops();
        logic [W+1:0] got;
        logic [W+1:0] exp;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        int           edges;
        int           p;
        bit           other;
        bit           to;
        run_op(0, 32'd1, 32'd2, OP_SLT, got, edges, other, to);
        checks++;
        if (to || got !== {1'b0, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL slt got=%h exp=%h", got, {1'b0, 1'b0, 32'd1});
        end
        run_op(1, 32'd0, 32'd0, OP_NOR, got, edges, other, to);
        checks++;
        if (to || got !== {1'b0, 1'b0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL nor got=%h exp=%h", got, {1'b0, 1'b0, 32'hFFFF_FFFF});
        end
        run_op(0, 32'h7FFF_FFFF, 32'd1, OP_ADD, got, edges, other, to);
        checks++;
        if (to || got !== {1'b1, 1'b0, 32'h8000_0000}) begin
            errors++;
            $display("FAIL add_ovf got=%h exp=%h", got, {1'b1, 1'b0, 32'h8000_0000});
        end
        for (int i = 0; i < 16; i++) begin
            p  = int'($urandom_range(1, 0));
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom_range(7, 0));
            if (i % 4 == 3) b = a;
            exp = ref_alu(a, b, op);
            run_op(p, a, b, op, got, edges, other, to);
            checks++;
            if (to || other || edges != 1 || got !== exp) begin
                errors++;
                $display("FAIL rand_op%0d p=%0d op=%b a=%h b=%h got=%h edges=%0d exp=%h",
                         i, p, op, a, b, got, edges, exp);
            end
        end
    endtask

    task automatic test_tie();
        logic [W-1:0] a0 [4];
        logic [W-1:0] b0 [4];
        logic [2:0]   o0 [4];
        logic [W-1:0] a1 [4];
        logic [W-1:0] b1 [4];
        logic [2:0]   o1 [4];
        int           exp_port_q [$];
        logic [W+1:0] exp_q [$];
        int           i0;
        int           i1;
        int           nresp;
        int           ngrant;
        int           last_cyc;
        int           g;
        int           rp;
        for (int k = 0; k < 4; k++) begin
            a0[k] = $urandom; b0[k] = $urandom; o0[k] = 3'($urandom_range(7, 0));
            a1[k] = $urandom; b1[k] = $urandom; o1[k] = 3'($urandom_range(7, 0));
        end
        reset_pulse();
        set_rsp_ready(0, 1'b1);
        set_rsp_ready(1, 1'b1);
        i0 = 0; i1 = 0; nresp = 0; ngrant = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 100 && nresp < 8; cyc++) begin
            if (port0.rsp_valid || port1.rsp_valid) begin
                rp = port1.rsp_valid ? 1 : 0;
                checks++;
                if ((port0.rsp_valid && port1.rsp_valid) || exp_q.size() == 0 ||
                    rp != exp_port_q[0] || rdata(rp) !== exp_q[0]) begin
                    errors++;
                    $display("FAIL tie_resp%0d port=%0d data=%h exp port=%0d data=%h", nresp, rp,
                             rdata(rp), (exp_port_q.size() > 0) ? exp_port_q[0] : -1,
                             (exp_q.size() > 0) ? exp_q[0] : '0);
                end
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_port_q.pop_front());
                end
                nresp++;
            end
            set_req(0, i0 < 4, a0[i0 % 4], b0[i0 % 4], o0[i0 % 4]);
            set_req(1, i1 < 4, a1[i1 % 4], b1[i1 % 4], o1[i1 % 4]);
            #1;
            if (port0.req_ready || port1.req_ready) begin
                g = port1.req_ready ? 1 : 0;
                checks++;
                if ((port0.req_ready && port1.req_ready) || g != ngrant % 2) begin
                    errors++;
                    $display("FAIL tie_grant%0d got=%b%b exp port %0d", ngrant,
                             port0.req_ready, port1.req_ready, ngrant % 2);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != 3) begin
                        errors++;
                        $display("FAIL tie_interval got=%0d exp=3", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                exp_port_q.push_back(g);
                if (g == 0) begin
                    exp_q.push_back(ref_alu(a0[i0], b0[i0], o0[i0]));
                    i0++;
                end else begin
                    exp_q.push_back(ref_alu(a1[i1], b1[i1], o1[i1]));
                    i1++;
                end
                ngrant++;
            end
            tick();
        end
        checks++;
        if (nresp != 8 || ngrant != 8) begin
            errors++;
            $display("FAIL tie_count got resp=%0d grant=%0d exp 8/8", nresp, ngrant);
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic test_backpressure();
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b1);
        set_req(0, 1'b1, 32'h8000_0000, 32'h0000_0100, OP_SRL);
        #1;
        checks++;
        if (port0.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept got=%b exp=1", port0.req_ready);
        end
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b1, 32'd9, 32'd4, OP_SUB);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({port0.rsp_valid, port0.rsp_res, port0.req_ready, port1.req_ready} !==
                {1'b1, 32'h0800_0000, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b res=%h rdy=%b%b exp v=1 res=08000000 rdy=00",
                         i, port0.rsp_valid, port0.rsp_res, port0.req_ready, port1.req_ready);
            end
            tick();
        end
        set_rsp_ready(0, 1'b1);
        #1;
        checks++;
        if (port1.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_early got=%b exp=0", port1.req_ready);
        end
        tick();
        #1;
        checks++;
        if ({port1.req_ready, port0.rsp_valid, port0.rsp_res} !== {2'b10, 32'h0800_0000}) begin
            errors++;
            $display("FAIL bp_release got rdy1=%b v0=%b res0=%h exp rdy1=1 v0=0 res0=08000000",
                     port1.req_ready, port0.rsp_valid, port0.rsp_res);
        end
        tick();
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        tick();
        checks++;
        if ({port1.rsp_valid, rdata(1)} !== {1'b1, 1'b0, 1'b0, 32'd5}) begin
            errors++;
            $display("FAIL bp_queued got v=%b data=%h exp v=1 data=5", port1.rsp_valid, rdata(1));
        end
        tick();
    endtask

    task automatic test_reset_exec();
        bit seen;
        set_rsp_ready(0, 1'b1);
        set_rsp_ready(1, 1'b1);
        set_req(0, 1'b1, 32'd11, 32'd22, OP_ADD);
        #1;
        tick();
        set_req(0, 1'b1, 32'd1, 32'd1, OP_OR);
        set_req(1, 1'b1, 32'd2, 32'd2, OP_OR);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({port0.rsp_valid, port0.req_ready, port1.req_ready, alu_a, alu_b, alu_op} !==
            {3'b000, W'(0), W'(0), 3'b000}) begin
            errors++;
            $display("FAIL rst_exec got v=%b rdy=%b%b a=%h b=%h op=%b exp all zero",
                     port0.rsp_valid, port0.req_ready, port1.req_ready, alu_a, alu_b, alu_op);
        end
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (port0.rsp_valid || port1.rsp_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_no_resp got rsp_valid=1 exp 0");
        end
        set_req(0, 1'b1, 32'd1, 32'd1, OP_OR);
        set_req(1, 1'b1, 32'd2, 32'd2, OP_OR);
        #1;
        checks++;
        if ({port0.req_ready, port1.req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_tie got=%b exp=10", {port0.req_ready, port1.req_ready});
        end
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        tick();
        tick();
        tick();
    endtask

    initial begin
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b0);
        test_reset();
        test_single_add();
        test_sub_zero();
        test_ops();
        test_tie();
        test_backpressure();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
